ex_mem: RTL and testbench

Pipeline register between the execute stage and the memory stage of the 5-stage MIPS core. Captures the EX result (destination register, write enable, write data), the HI/LO write request, and load/store information (aluop, address, store data) on each rising clock edge. Implements the core's stall-bus and flush semantics: bubble insertion, hold, and clear. Also carries the two-cycle multiply-accumulate intermediate (hilo_temp, cnt) from EX back into EX on the following cycle.

---
 rtl/ex_mem.sv | 122 ++++++++++++
 tb/tb_ex_mem.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ex_mem.sv
// EX/MEM pipeline register: EX result, HI/LO request and load/store info, with bubble/hold/flush.
// Optional EX_MEM_MADD_EN carries the madd/msub partial product and cycle count back into EX.
module ex_mem (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [4:0]  ex_wd,
  input  logic        ex_wreg,
  input  logic [31:0] ex_wdata,
  input  logic [31:0] ex_hi,
  input  logic [31:0] ex_lo,
  input  logic        ex_whilo,
  input  logic [7:0]  ex_aluop,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_reg2,
  input  logic [63:0] hilo_temp_i,
  input  logic [1:0]  cnt_i,
  output logic [4:0]  mem_wd,
  output logic        mem_wreg,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_hi,
  output logic [31:0] mem_lo,
  output logic        mem_whilo,
  output logic [7:0]  mem_aluop,
  output logic [31:0] mem_mem_addr,
  output logic [31:0] mem_reg2,
  output logic        mem_valid,
  output logic [63:0] hilo_temp_o,
  output logic [1:0]  cnt_o
);

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        whilo;
    logic [7:0]  aluop;
    logic [31:0] addr;
    logic [31:0] reg2;
    logic        valid;
  } mem_pkt_t;

  mem_pkt_t pkt_d, pkt_q;
  logic     bubble, hold;

  // stall[4] without stall[3] never occurs; it falls through to pass-through.
  assign bubble = stall[3] & ~stall[4];
  assign hold   = stall[3] &  stall[4];

  always_comb begin
    pkt_d = pkt_q;
    if (flush || bubble) begin
      pkt_d = '0;
    end else if (!hold) begin
      pkt_d = '{wd: ex_wd, wreg: ex_wreg, wdata: ex_wdata, hi: ex_hi, lo: ex_lo,
                whilo: ex_whilo, aluop: ex_aluop, addr: ex_mem_addr, reg2: ex_reg2,
                valid: 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pkt_q <= '0;
    else     pkt_q <= pkt_d;
  end

  assign mem_wd       = pkt_q.wd;
  assign mem_wreg     = pkt_q.wreg;
  assign mem_wdata    = pkt_q.wdata;
  assign mem_hi       = pkt_q.hi;
  assign mem_lo       = pkt_q.lo;
  assign mem_whilo    = pkt_q.whilo;
  assign mem_aluop    = pkt_q.aluop;
  assign mem_mem_addr = pkt_q.addr;
  assign mem_reg2     = pkt_q.reg2;
  assign mem_valid    = pkt_q.valid;

`ifdef EX_MEM_MADD_EN
  logic [63:0] hilo_temp_d, hilo_temp_q;
  logic [1:0]  cnt_d, cnt_q;

  // A bubble keeps the accumulate progress alive; a real pass-through ends it.
  always_comb begin
    hilo_temp_d = hilo_temp_q;
    cnt_d       = cnt_q;
    if (flush) begin
      hilo_temp_d = '0;
      cnt_d       = '0;
    end else if (bubble) begin
      hilo_temp_d = hilo_temp_i;
      cnt_d       = cnt_i;
    end else if (!hold) begin
      hilo_temp_d = '0;
      cnt_d       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hilo_temp_q <= '0;
      cnt_q       <= '0;
    end else begin
      hilo_temp_q <= hilo_temp_d;
      cnt_q       <= cnt_d;
    end
  end

  assign hilo_temp_o = hilo_temp_q;
  assign cnt_o       = cnt_q;
`else
  logic unused_madd;
  assign unused_madd = ^{hilo_temp_i, cnt_i};
  assign hilo_temp_o = '0;
  assign cnt_o       = '0;
`endif

  logic unused_stall;
  assign unused_stall = ^{stall[5], stall[2:0]};

endmodule

// File: tb/tb_ex_mem.sv
// Directed bench for ex_mem: reset, pass-through, bubble, hold, flush priority, HI/LO and load/store fields.
module tb_ex_mem;

`ifdef EX_MEM_MADD_EN
  localparam bit MADD = 1'b1;
`else
  localparam bit MADD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, flush;
  logic [5:0]  stall;
  logic [4:0]  ex_wd;
  logic        ex_wreg, ex_whilo;
  logic [31:0] ex_wdata, ex_hi, ex_lo, ex_mem_addr, ex_reg2;
  logic [7:0]  ex_aluop;
  logic [63:0] hilo_temp_i;
  logic [1:0]  cnt_i;
  logic [4:0]  mem_wd;
  logic        mem_wreg, mem_whilo, mem_valid;
  logic [31:0] mem_wdata, mem_hi, mem_lo, mem_mem_addr, mem_reg2;
  logic [7:0]  mem_aluop;
  logic [63:0] hilo_temp_o;
  logic [1:0]  cnt_o;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  ex_mem dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_hi(ex_hi), .ex_lo(ex_lo),
    .ex_whilo(ex_whilo), .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
    .hilo_temp_i(hilo_temp_i), .cnt_i(cnt_i),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_hi(mem_hi),
    .mem_lo(mem_lo), .mem_whilo(mem_whilo), .mem_aluop(mem_aluop),
    .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2), .mem_valid(mem_valid),
    .hilo_temp_o(hilo_temp_o), .cnt_o(cnt_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    ex_wd = '0; ex_wreg = 1'b0; ex_wdata = '0; ex_hi = '0; ex_lo = '0; ex_whilo = 1'b0;
    ex_aluop = '0; ex_mem_addr = '0; ex_reg2 = '0; hilo_temp_i = '0; cnt_i = '0;
  endtask

  // The stall controller never raises MEM stall without EX stall.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(stall[4] && !stall[3]))
      else begin
        checks++;
        $error("FAIL illegal_stall: got %b expected stall[4] only with stall[3]", stall);
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; stall = '0;
    ex_wd = 5'd31; ex_wreg = 1'b1; ex_wdata = 32'hFFFF_FFFF; ex_hi = 32'h1111_1111;
    ex_lo = 32'h2222_2222; ex_whilo = 1'b1; ex_aluop = 8'hFF; ex_mem_addr = 32'h3333_3333;
    ex_reg2 = 32'h4444_4444; hilo_temp_i = 64'h5555_5555_5555_5555; cnt_i = 2'd2;
    tick(); tick();
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_wreg",  mem_wreg, 0);
    chk("rst_wd",    mem_wd, 0);
    chk("rst_hi",    mem_hi, 0);
    chk("rst_aluop", mem_aluop, 0);
    chk("rst_valid", mem_valid, 0);
    chk("rst_hilo",  hilo_temp_o, 0);
    chk("rst_cnt",   cnt_o, 0);

    rst = 1'b0; clear_ex();
    ex_wd = 5'd3; ex_wreg = 1'b1; ex_wdata = 32'h1234_5678;
    tick();
    chk("pass_wd",    mem_wd, 5'd3);
    chk("pass_wreg",  mem_wreg, 1);
    chk("pass_wdata", mem_wdata, 32'h1234_5678);
    chk("pass_valid", mem_valid, 1);

    // Bubble
    stall = 6'b001111; ex_wdata = 32'hDEAD_BEEF; ex_wd = 5'd7; hilo_temp_i = 64'h1; cnt_i = 2'd1;
    tick();
    chk("bub_wreg",  mem_wreg, 0);
    chk("bub_wdata", mem_wdata, 0);
    chk("bub_valid", mem_valid, 0);
    chk("bub_hilo",  hilo_temp_o, MADD ? 64'h1 : 64'h0);
    chk("bub_cnt",   cnt_o, MADD ? 2'd1 : 2'd0);

    // Release: instruction waiting in EX appears one edge later
    stall = '0;
    tick();
    chk("rel_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("rel_wd",    mem_wd, 5'd7);
    chk("rel_valid", mem_valid, 1);
    chk("rel_cnt",   cnt_o, 0);
    chk("rel_hilo",  hilo_temp_o, 0);

    // Hold
    ex_wdata = 32'hAAAA_5555;
    tick();
    chk("load_wdata", mem_wdata, 32'hAAAA_5555);
    stall = 6'b011111;
    for (int i = 0; i < 3; i++) begin
      ex_wdata = 32'h100 + i; ex_wd = 5'(i); cnt_i = 2'(i + 1); hilo_temp_i = 64'(i + 9);
      tick();
      chk("hold_wdata", mem_wdata, 32'hAAAA_5555);
      chk("hold_cnt",   cnt_o, 0);
      chk("hold_valid", mem_valid, 1);
    end

    // Bubble with progress, then hold must keep cnt/hilo
    stall = 6'b001111; cnt_i = 2'd1; hilo_temp_i = 64'hABCD;
    tick();
    stall = 6'b011111; cnt_i = 2'd2; hilo_temp_i = 64'h9999;
    tick();
    chk("hold2_cnt",   cnt_o, MADD ? 2'd1 : 2'd0);
    chk("hold2_hilo",  hilo_temp_o, MADD ? 64'hABCD : 64'h0);
    chk("hold2_valid", mem_valid, 0);

    // Flush mid-madd clears the carry-back
    stall = 6'b001111; flush = 1'b1;
    tick();
    chk("flmadd_cnt",  cnt_o, 0);
    chk("flmadd_hilo", hilo_temp_o, 0);
    flush = 1'b0;

    // Flush beats hold
    stall = '0; clear_ex(); ex_wreg = 1'b1; ex_wd = 5'd9; ex_wdata = 32'h55;
    tick();
    chk("pre_fl_valid", mem_valid, 1);
    flush = 1'b1; stall = 6'b011111;
    tick();
    chk("fl_wdata", mem_wdata, 0);
    chk("fl_wd",    mem_wd, 0);
    chk("fl_valid", mem_valid, 0);
    flush = 1'b0; stall = '0;

    // HI/LO
    clear_ex(); ex_whilo = 1'b1; ex_hi = 32'hFFFF_0000; ex_lo = 32'h0000_FFFF;
    tick();
    chk("hl_whilo", mem_whilo, 1);
    chk("hl_hi",    mem_hi, 32'hFFFF_0000);
    chk("hl_lo",    mem_lo, 32'h0000_FFFF);
    ex_whilo = 1'b0;
    tick();
    chk("hl_whilo0", mem_whilo, 0);

    // Load/store fields
    clear_ex(); ex_aluop = 8'hE3; ex_mem_addr = 32'h0000_0104; ex_reg2 = 32'hCAFE_F00D;
    tick();
    chk("ls_aluop", mem_aluop, 8'hE3);
    chk("ls_addr",  mem_mem_addr, 32'h0000_0104);
    chk("ls_reg2",  mem_reg2, 32'hCAFE_F00D);
    cnt_i = 2'd3; hilo_temp_i = 64'hFEED;
    tick();
    chk("ls_cnt",  cnt_o, 0);
    chk("ls_hilo", hilo_temp_o, 0);

    // Reset mid-stream
    ex_wdata = 32'h7777; ex_wreg = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    chk("rst2_wdata", mem_wdata, 0);
    chk("rst2_valid", mem_valid, 0);
    rst = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
